line_arbiter_n: RTL and testbench

Parametrised N-port cacheline memory arbiter placed between the L1 caches / prefetcher and the eviction write buffer. Generalises the fixed three-client arbiter to NUM_PORTS requesters, configurable line and address widths, and selectable fixed-priority or round-robin arbitration. The winning request's operation, address and write data are latched, so the downstream port stays stable for the whole transaction. Exactly one line transaction is outstanding downstream at any time.

---
 rtl/line_arbiter_n.sv | 107 ++++++++++
 tb/tb_line_arbiter_n.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/line_arbiter_n.sv
// rtl/line_arbiter_n.sv - N-port cacheline arbiter, fixed-priority or round-robin
// One line transaction outstanding downstream; winner's op/address/wdata are latched.
module line_arbiter_n #(
   parameter int NUM_PORTS  = 3,
   parameter int LINE_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int RR_MODE    = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             req_read,
   input  logic [NUM_PORTS-1:0]             req_write,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_address,
   input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             req_resp,
   output logic [LINE_WIDTH-1:0]            req_rdata,
   input  logic                             mem_resp,
   input  logic [LINE_WIDTH-1:0]            mem_rdata,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [LINE_WIDTH-1:0]            mem_wdata,
   output logic                             busy
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0]            state;
   logic [PTR_W-1:0]      rr_ptr;
   logic [PTR_W-1:0]      grant;
   logic                  op_write;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LINE_WIDTH-1:0] wdata_q;

   logic [NUM_PORTS-1:0]  pending;
   logic [PTR_W:0]        cand;
   logic [PTR_W-1:0]      win_idx;
   logic                  win_found;

   assign pending = req_read | req_write;

   // Scan ports starting at rr_ptr (or 0 in fixed mode), wrapping modulo NUM_PORTS.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (RR_MODE != 0)
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         else
            cand = (PTR_W+1)'(k);
         if (cand >= (PTR_W+1)'(NUM_PORTS))
            cand = cand - (PTR_W+1)'(NUM_PORTS);
         if (!win_found && pending[cand[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[PTR_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         grant    <= '0;
         op_write <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  state    <= ST_BUSY;
                  grant    <= win_idx;
                  op_write <= req_write[win_idx];
                  addr_q   <= req_address[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  wdata_q  <= req_wdata[win_idx*LINE_WIDTH +: LINE_WIDTH];
               end
            end
            ST_BUSY: begin
               if (mem_resp) begin
                  state  <= ST_IDLE;
                  rr_ptr <= (grant == PTR_W'(NUM_PORTS-1)) ? '0 : grant + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy        = (state == ST_BUSY);
   assign mem_read    = busy & ~op_write;
   assign mem_write   = busy & op_write;
   assign mem_address = addr_q;
   assign mem_wdata   = wdata_q;
   assign req_rdata   = mem_rdata;

   always_comb begin
      req_resp = '0;
      if (busy && mem_resp)
         req_resp[grant] = 1'b1;
   end

endmodule

// File: tb/tb_line_arbiter_n.sv
// tb/tb_line_arbiter_n.sv - directed bench for line_arbiter_n
// Fixed-priority instance (3 ports) and round-robin instance (4 ports) share clk/rst.
module tb_line_arbiter_n;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]     f_rd, f_wr, f_resp;
   logic [95:0]    f_addr;
   logic [767:0]   f_wdata;
   logic [255:0]   f_rdata, f_mrdata, f_mwdata;
   logic           f_mresp, f_mread, f_mwrite, f_busy;
   logic [31:0]    f_maddr;

   logic [3:0]     r_rd, r_wr, r_resp;
   logic [127:0]   r_addr;
   logic [1023:0]  r_wdata;
   logic [255:0]   r_rdata, r_mrdata, r_mwdata;
   logic           r_mresp, r_mread, r_mwrite, r_busy;
   logic [31:0]    r_maddr;

   line_arbiter_n #(.NUM_PORTS(3), .LINE_WIDTH(256), .ADDR_WIDTH(32), .RR_MODE(0)) dut_fx (
      .clk(clk), .rst(rst), .req_read(f_rd), .req_write(f_wr), .req_address(f_addr),
      .req_wdata(f_wdata), .req_resp(f_resp), .req_rdata(f_rdata), .mem_resp(f_mresp),
      .mem_rdata(f_mrdata), .mem_read(f_mread), .mem_write(f_mwrite),
      .mem_address(f_maddr), .mem_wdata(f_mwdata), .busy(f_busy));

   line_arbiter_n #(.NUM_PORTS(4), .LINE_WIDTH(256), .ADDR_WIDTH(32), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .req_read(r_rd), .req_write(r_wr), .req_address(r_addr),
      .req_wdata(r_wdata), .req_resp(r_resp), .req_rdata(r_rdata), .mem_resp(r_mresp),
      .mem_rdata(r_mrdata), .mem_read(r_mread), .mem_write(r_mwrite),
      .mem_address(r_maddr), .mem_wdata(r_mwdata), .busy(r_busy));

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [255:0] LINE_AA = {32{8'hAA}};
   localparam logic [255:0] LINE_55 = {32{8'h55}};

   int rr_port [5] = '{0, 1, 2, 3, 0};

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs are driven just after the falling edge; outputs checked 1 time unit later.
   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      f_rd = '0; f_wr = '0; f_addr = '0; f_wdata = '0; f_mresp = 1'b0; f_mrdata = '0;
      r_rd = '0; r_wr = '0; r_addr = '0; r_wdata = '0; r_mresp = 1'b0; r_mrdata = '0;
      r_addr[0*32 +: 32] = 32'h100;
      r_addr[1*32 +: 32] = 32'h200;
      r_addr[2*32 +: 32] = 32'h300;
      r_addr[3*32 +: 32] = 32'h400;
      step(); step(); #1;
      chk("rst_busy",   256'(f_busy), 256'd0);
      chk("rst_mread",  256'(f_mread), 256'd0);
      chk("rst_mwrite", 256'(f_mwrite), 256'd0);
      chk("rst_maddr",  256'(f_maddr), 256'd0);
      chk("rst_rr_busy", 256'(r_busy), 256'd0);
      rst = 1'b0;

      // single read from port 1
      step();
      f_rd = 3'b010; f_addr[1*32 +: 32] = 32'h0000_1000; #1;
      chk("rd_c0_mread", 256'(f_mread), 256'd0);
      step(); #1;
      chk("rd_c1_mread", 256'(f_mread), 256'd1);
      chk("rd_c1_mwrite", 256'(f_mwrite), 256'd0);
      chk("rd_c1_maddr", 256'(f_maddr), 256'h1000);
      chk("rd_c1_busy", 256'(f_busy), 256'd1);
      step(); step(); step();
      step(); f_mresp = 1'b1; f_mrdata = LINE_AA; #1;
      chk("rd_c5_resp", 256'(f_resp), 256'b010);
      chk("rd_c5_rdata", f_rdata, LINE_AA);
      step(); f_mresp = 1'b0; f_rd = '0; #1;
      chk("rd_c6_busy", 256'(f_busy), 256'd0);
      chk("rd_c6_resp", 256'(f_resp), 256'd0);

      // fixed priority: port 0 keeps winning while held
      f_addr[0*32 +: 32] = 32'h100;
      f_addr[1*32 +: 32] = 32'h200;
      f_addr[2*32 +: 32] = 32'h300;
      step(); f_rd = 3'b111;
      for (int i = 0; i < 3; i++) begin
         step(); f_mresp = 1'b1; #1;
         chk("fx_p0_maddr", 256'(f_maddr), 256'h100);
         chk("fx_p0_resp", 256'(f_resp), 256'b001);
         step(); f_mresp = 1'b0; #1;
         chk("fx_idle_busy", 256'(f_busy), 256'd0);
      end
      f_rd = 3'b110;
      step(); f_mresp = 1'b1; #1;
      chk("fx_p1_maddr", 256'(f_maddr), 256'h200);
      chk("fx_p1_resp", 256'(f_resp), 256'b010);
      step(); f_mresp = 1'b0; f_rd = '0; #1;
      chk("fx_end_busy", 256'(f_busy), 256'd0);

      // write latching: requester changes inputs during BUSY
      step(); f_wr = 3'b001; f_addr[0*32 +: 32] = 32'h2000; f_wdata[0*256 +: 256] = LINE_55;
      step(); #1;
      chk("wr_mwrite", 256'(f_mwrite), 256'd1);
      chk("wr_mread", 256'(f_mread), 256'd0);
      chk("wr_maddr", 256'(f_maddr), 256'h2000);
      chk("wr_mwdata", f_mwdata, LINE_55);
      f_addr[0*32 +: 32] = 32'h3000; f_wdata[0*256 +: 256] = '0;
      step(); #1;
      chk("wr_hold_maddr", 256'(f_maddr), 256'h2000);
      chk("wr_hold_mwdata", f_mwdata, LINE_55);
      step(); f_mresp = 1'b1; #1;
      chk("wr_resp", 256'(f_resp), 256'b001);
      chk("wr_resp_maddr", 256'(f_maddr), 256'h2000);
      step(); f_mresp = 1'b0; f_wr = '0; #1;
      chk("wr_end_busy", 256'(f_busy), 256'd0);

      // read+write on the same port: write wins
      step(); f_rd = 3'b100; f_wr = 3'b100; f_addr[2*32 +: 32] = 32'h4000;
      step(); #1;
      chk("rw_mwrite", 256'(f_mwrite), 256'd1);
      chk("rw_mread", 256'(f_mread), 256'd0);
      chk("rw_maddr", 256'(f_maddr), 256'h4000);
      step(); f_mresp = 1'b1; #1;
      chk("rw_resp", 256'(f_resp), 256'b100);
      step(); f_mresp = 1'b0; f_rd = '0; f_wr = '0; #1;
      chk("rw_end_busy", 256'(f_busy), 256'd0);

      // asynchronous reset while a read is outstanding
      f_addr[0*32 +: 32] = 32'h100;
      f_addr[2*32 +: 32] = 32'h300;
      step(); f_rd = 3'b001;
      step(); #1;
      chk("ar_pre_mread", 256'(f_mread), 256'd1);
      f_rd = '0;
      #2 rst = 1'b1; f_mresp = 1'b1; #1;
      chk("ar_mread", 256'(f_mread), 256'd0);
      chk("ar_busy", 256'(f_busy), 256'd0);
      chk("ar_resp", 256'(f_resp), 256'd0);
      step(); rst = 1'b0; f_mresp = 1'b0;
      step();
      step(); f_mresp = 1'b1; #1;
      chk("ar_late_resp", 256'(f_resp), 256'd0);
      chk("ar_late_busy", 256'(f_busy), 256'd0);
      step(); f_mresp = 1'b0; #1;
      chk("ar_after_busy", 256'(f_busy), 256'd0);

      // back-to-back with one-cycle memory latency
      step(); f_rd = 3'b011; #1;
      chk("bb_c0_strobe", 256'(f_mread), 256'd0);
      step(); f_mresp = 1'b1; #1;
      chk("bb_c1_strobe", 256'(f_mread), 256'd1);
      chk("bb_c1_resp", 256'(f_resp), 256'b001);
      step(); f_mresp = 1'b0; f_rd = 3'b010; #1;
      chk("bb_c2_strobe", 256'(f_mread), 256'd0);
      chk("bb_c2_resp", 256'(f_resp), 256'd0);
      step(); f_mresp = 1'b1; #1;
      chk("bb_c3_strobe", 256'(f_mread), 256'd1);
      chk("bb_c3_maddr", 256'(f_maddr), 256'h200);
      chk("bb_c3_resp", 256'(f_resp), 256'b010);
      step(); f_mresp = 1'b0; f_rd = '0; #1;
      chk("bb_c4_strobe", 256'(f_mread), 256'd0);

      // round-robin, all four ports pending continuously
      step(); r_rd = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step(); r_mresp = 1'b1; #1;
         chk("rr_all_maddr", 256'(r_maddr), 256'(32'h100 * (rr_port[i] + 1)));
         chk("rr_all_resp", 256'(r_resp), 256'(4'b0001 << rr_port[i]));
         step(); r_mresp = 1'b0; #1;
         chk("rr_all_idle", 256'(r_busy), 256'd0);
      end
      // rr_ptr is 1 here; serving port 1 moves it to 2
      r_rd = 4'b0010;
      step(); r_mresp = 1'b1; #1;
      chk("rr_p1_resp", 256'(r_resp), 256'b0010);
      step(); r_mresp = 1'b0; r_rd = 4'b1010;
      step(); r_mresp = 1'b1; #1;
      chk("rr_wrap_p3_maddr", 256'(r_maddr), 256'h400);
      chk("rr_wrap_p3_resp", 256'(r_resp), 256'b1000);
      step(); r_mresp = 1'b0; r_rd = 4'b0010;
      step(); r_mresp = 1'b1; #1;
      chk("rr_wrap_p1_maddr", 256'(r_maddr), 256'h200);
      chk("rr_wrap_p1_resp", 256'(r_resp), 256'b0010);
      step(); r_mresp = 1'b0; r_rd = '0; #1;
      chk("rr_end_busy", 256'(r_busy), 256'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
